// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and EX/MEM, MEM/WB operand forwarding.
// Feeds the ALU operands and function code directly in the EX cycle.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [RA_W-1:0] id_rs1_addr,
  input  logic [RA_W-1:0] id_rs2_addr,
  input  logic [RA_W-1:0] id_rd_addr,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [2:0]      id_alu_control,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_mem_to_reg,
  input  logic            exmem_reg_write,
  input  logic [RA_W-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [RA_W-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_data,
  output logic            stall_o,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_control,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic [RA_W-1:0] ex_rd,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_store_data
);

  logic            r_valid;
  logic            r_reg_write;
  logic            r_mem_read;
  logic            r_mem_write;
  logic            r_mem_to_reg;
  logic [2:0]      r_alu_control;
  logic            r_alu_src;
  logic [RA_W-1:0] r_rd;
  logic [RA_W-1:0] r_rs1_addr;
  logic [RA_W-1:0] r_rs2_addr;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_pc;

  logic            w_hit_rs1;
  logic            w_hit_rs2;
  logic            w_stall;
  logic            w_bubble;
  logic [XLEN-1:0] w_fwd_rs1;
  logic [XLEN-1:0] w_fwd_rs2;

  // x0 is never forwarded; EX/MEM is younger than MEM/WB so it takes precedence
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [RA_W-1:0] addr,
    input logic [XLEN-1:0] rf_data,
    input logic            em_we,
    input logic [RA_W-1:0] em_rd,
    input logic [XLEN-1:0] em_val,
    input logic            mw_we,
    input logic [RA_W-1:0] mw_rd,
    input logic [XLEN-1:0] mw_val
  );
    logic [XLEN-1:0] res;
    if (addr == {RA_W{1'b0}}) begin
      res = rf_data;
    end else if (em_we && (em_rd == addr)) begin
      res = em_val;
    end else if (mw_we && (mw_rd == addr)) begin
      res = mw_val;
    end else begin
      res = rf_data;
    end
    return res;
  endfunction

  // Load-use hazard: the load in EX produces data the ID instruction needs next cycle
  always_comb begin
    w_hit_rs1 = id_uses_rs1 && (id_rs1_addr == r_rd);
    w_hit_rs2 = id_uses_rs2 && (id_rs2_addr == r_rd);
    w_stall   = r_valid && r_mem_read && (r_rd != {RA_W{1'b0}}) && id_valid && !flush_i
                && (w_hit_rs1 || w_hit_rs2);
    w_bubble  = flush_i || w_stall;
  end

  // Pipeline register: rst > flush > stall > load
  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      r_valid       <= 1'b0;
      r_reg_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_alu_control <= 3'b000;
      r_alu_src     <= 1'b0;
      r_rd          <= {RA_W{1'b0}};
      r_rs1_addr    <= {RA_W{1'b0}};
      r_rs2_addr    <= {RA_W{1'b0}};
      r_rs1_data    <= {XLEN{1'b0}};
      r_rs2_data    <= {XLEN{1'b0}};
      r_imm         <= {XLEN{1'b0}};
      r_pc          <= {XLEN{1'b0}};
    end else begin
      r_valid       <= id_valid;
      r_reg_write   <= id_reg_write  && id_valid;
      r_mem_read    <= id_mem_read   && id_valid;
      r_mem_write   <= id_mem_write  && id_valid;
      r_mem_to_reg  <= id_mem_to_reg && id_valid;
      r_alu_control <= id_alu_control;
      r_alu_src     <= id_alu_src;
      r_rd          <= id_rd_addr;
      r_rs1_addr    <= id_rs1_addr;
      r_rs2_addr    <= id_rs2_addr;
      r_rs1_data    <= id_rs1_data;
      r_rs2_data    <= id_rs2_data;
      r_imm         <= id_imm;
      r_pc          <= id_pc;
    end
  end

  // Zero-latency forwarding into the ALU operand muxes
  always_comb begin
    w_fwd_rs1 = fwd_sel(r_rs1_addr, r_rs1_data, exmem_reg_write, exmem_rd, exmem_result,
                        memwb_reg_write, memwb_rd, memwb_data);
    w_fwd_rs2 = fwd_sel(r_rs2_addr, r_rs2_data, exmem_reg_write, exmem_rd, exmem_result,
                        memwb_reg_write, memwb_rd, memwb_data);
  end

  assign stall_o       = w_stall;
  assign alu_a         = w_fwd_rs1;
  assign alu_b         = r_alu_src ? r_imm : w_fwd_rs2;
  assign ex_store_data = w_fwd_rs2;
  assign alu_control   = r_alu_control;
  assign ex_valid      = r_valid;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_mem_to_reg = r_mem_to_reg;
  assign ex_rd         = r_rd;
  assign ex_pc         = r_pc;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the RISC-V core; sits directly upstream of the ALU.
- Registers decoded instruction fields at each clock edge.
- Resolves operand forwarding from the EX/MEM and MEM/WB stages.
- Detects load-use hazards and inserts bubbles; drives the ALU's a, b and 3-bit alu_control inputs.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register address width.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- flush_i  in  1  branch/jump redirect; kills the instruction entering EX.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  XLEN  PC of ID instruction.
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  RA_W each  register specifiers.
- id_uses_rs1, id_uses_rs2  in  1 each  operand actually read.
- id_rs1_data, id_rs2_data  in  XLEN each  register file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_alu_control  in  3  ALU function code (000 add ... 111 slt).
- id_alu_src  in  1  1 = ALU b takes immediate.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control bits.
- exmem_reg_write  in  1;  exmem_rd  in  RA_W;  exmem_result  in  XLEN  EX/MEM forward source.
- memwb_reg_write  in  1;  memwb_rd  in  RA_W;  memwb_data  in  XLEN  MEM/WB forward source.
- stall_o  out  1  combinational; holds PC and IF/ID when 1.
- alu_a, alu_b  out  XLEN  ALU operands (combinational from registered fields plus forwarding).
- alu_control  out  3  registered function code.
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  registered controls.
- ex_rd  out  RA_W;  ex_pc  out  XLEN;  ex_store_data  out  XLEN  forwarded rs2 for stores.

Behaviour:
- Register update priority each rising edge: rst > flush_i > stall_o > normal load.
- Bubble: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg = 0; alu_control = 000; rd/addresses/data/pc/imm = 0.
- rst: load bubble. All registered outputs read 0 the cycle after reset is sampled. Reset mid-stream discards the EX instruction.
- flush_i=1: load bubble regardless of stall_o.
- stall_o=1 (and no flush): load bubble. Upstream holds ID, so the same instruction is presented again next cycle.
- Normal load: capture all id_* fields; ex_valid = id_valid. If id_valid=0, control bits are also forced 0.
- stall_o = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & ~flush_i & ((id_uses_rs1 & id_rs1_addr==ex_rd) | (id_uses_rs2 & id_rs2_addr==ex_rd)).
  - Exactly one bubble per load-use pair. Next cycle the load is in MEM and ex_mem_read=0.
- Forwarding per registered source address s (rs1, rs2):
  - If s==0: use registered read data (no forwarding of x0).
  - Else if exmem_reg_write & exmem_rd==s: use exmem_result. EX/MEM wins over MEM/WB.
  - Else if memwb_reg_write & memwb_rd==s: use memwb_data.
  - Else: use registered register file data.
- alu_a = fwd_rs1. alu_b = ex_alu_src ? ex_imm : fwd_rs2. ex_store_data = fwd_rs2 always.
- Forward muxes are purely combinational; latency ID->EX is one cycle, forward path zero cycles.
- The block does not compute results; the ALU consumes alu_a/alu_b/alu_control in the same cycle.

Test Plan:
- Reset: hold rst 2 cycles with random id_* inputs -> all ex_* = 0, alu_control=000, alu_a=0, stall_o=0. First non-reset edge loads the ID instruction.
- Plain load: id add x3,x1,x2, rs1_data=5, rs2_data=7, alu_src=0, no forward hits -> next cycle alu_a=5, alu_b=7, alu_control=000, ex_rd=3, ex_reg_write=1.
- Forward priority: EX holds rs1=x4, rs2=x4; exmem_rd=4/result=0x11 and memwb_rd=4/data=0x22 both writing -> alu_a=0x11, ex_store_data=0x11. Drop exmem_reg_write -> both read 0x22. x0 source with exmem_rd=0 writing 0x99 -> register data used.
- Load-use: EX lw x5 (mem_read=1), ID add x6,x5,x1 with uses_rs1=1 -> stall_o=1 for exactly one cycle, bubble enters EX. The following cycle the add loads, with x5 supplied via memwb/exmem forward.
- Load-use masked: same hazard with id_rs1_addr=x5 but id_uses_rs1=0, or ex_rd=0 -> stall_o=0.
- Flush vs stall: load-use stall condition plus flush_i=1 -> stall_o=0, bubble loaded. Immediate op with alu_src=1, imm=0xFFFFFFF0 -> alu_b=0xFFFFFFF0 while ex_store_data still equals forwarded rs2.
